// File: rtl/cpu_pkg.sv
// Shared MIPS-Lite definitions: opcode constants and the hazard FSM state type.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for MIPS-Lite: load-use and ID-branch operand stalls,
// taken-branch/jump IF/ID flush, and saturating stall/flush event counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_taken,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_wn,
    input  logic             mem_memread,
    input  logic [4:0]       mem_wn,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state_q, state_d;
    logic [1:0] remaining_q, remaining_d;

    logic       is_br, uses_rt, match_ex, match_mem;
    logic [1:0] need;
    logic       pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

    always_comb begin
        is_br     = (id_op == OP_BEQ);
        uses_rt   = (id_op == OP_RTYPE) || (id_op == OP_BEQ) || (id_op == OP_SW);
        match_ex  = (ex_wn != 5'd0) &&
                    ((ex_wn == id_rs) || (uses_rt && (ex_wn == id_rt)));
        match_mem = (mem_wn != 5'd0) &&
                    ((mem_wn == id_rs) || (uses_rt && (mem_wn == id_rt)));

        // A load feeding a branch must reach WB-forwardable MEM/WB: two bubbles.
        if (is_br && ex_memread && match_ex) begin
            need = 2'd2;
        end else if (ex_memread && match_ex) begin
            need = 2'd1;
        end else if (is_br && ex_regwrite && match_ex) begin
            need = 2'd1;
        end else if (is_br && mem_memread && match_mem) begin
            need = 2'd1;
        end else begin
            need = 2'd0;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;

        if (hold) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (need != 2'd0) begin
                        // Branch operands are stale, so taken/jump is ignored here.
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                        if (need == 2'd2) begin
                            state_d     = STALL;
                            remaining_d = 2'd1;
                        end
                    end else if (id_taken || id_jump) begin
                        ifid_flush_c = 1'b1;
                    end
                end
                STALL: begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                    remaining_d   = remaining_q - 2'd1;
                    if (remaining_d == 2'd0) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d     = RUN;
                    remaining_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            remaining_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // While reset is low the outputs must show reset values whatever ID holds.
    assign pc_write    = !rst_n || pc_write_c;
    assign ifid_write  = !rst_n || ifid_write_c;
    assign ifid_flush  = rst_n && ifid_flush_c;
    assign idex_bubble = rst_n && idex_bubble_c;
    assign busy        = rst_n && (state_q == STALL);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (idex_bubble),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against a
// pending-bubble model; a second instance with 2-bit counters covers saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [5:0]  id_op = 6'd0;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_taken = 1'b0;
    logic        id_jump = 1'b0;
    logic        ex_memread = 1'b0;
    logic        ex_regwrite = 1'b0;
    logic [4:0]  ex_wn = 5'd0;
    logic        mem_memread = 1'b0;
    logic [4:0]  mem_wn = 5'd0;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2, busy2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;

    // Model state: bubbles still owed after the current cycle, and event counts.
    int pend = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_stall2 = 0;
    int m_flush2 = 0;
    int exp_n;
    logic exp_pc, exp_ifid, exp_flush, exp_bub, exp_busy;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_taken(id_taken), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wn(ex_wn),
        .mem_memread(mem_memread), .mem_wn(mem_wn), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .busy(busy), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_taken(id_taken), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wn(ex_wn),
        .mem_memread(mem_memread), .mem_wn(mem_wn), .pc_write(pc_write2),
        .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
        .idex_bubble(idex_bubble2), .busy(busy2), .stall_cnt(stall_cnt2),
        .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        bit rt_used;
        rt_used = (id_op == 6'd0) || (id_op == 6'd4) || (id_op == 6'd43);
        return (r != 5'd0) && ((r == id_rs) || (rt_used && (r == id_rt)));
    endfunction

    function automatic int model_need();
        bit br;
        br = (id_op == 6'd4);
        if (br && ex_memread && reads(ex_wn)) return 2;
        if (ex_memread && reads(ex_wn)) return 1;
        if (br && ex_regwrite && reads(ex_wn)) return 1;
        if (br && mem_memread && reads(mem_wn)) return 1;
        return 0;
    endfunction

    task automatic predict();
        exp_busy = (pend > 0);
        exp_n = 0;
        exp_pc = 1'b1; exp_ifid = 1'b1; exp_flush = 1'b0; exp_bub = 1'b0;
        if (hold) begin
            exp_pc = 1'b0; exp_ifid = 1'b0;
        end else if (pend > 0) begin
            exp_pc = 1'b0; exp_ifid = 1'b0; exp_bub = 1'b1;
        end else begin
            exp_n = model_need();
            if (exp_n > 0) begin
                exp_pc = 1'b0; exp_ifid = 1'b0; exp_bub = 1'b1;
            end else begin
                exp_flush = id_taken | id_jump;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_write"}, int'(pc_write), int'(exp_pc));
        chk({tag, ".ifid_write"}, int'(ifid_write), int'(exp_ifid));
        chk({tag, ".ifid_flush"}, int'(ifid_flush), int'(exp_flush));
        chk({tag, ".idex_bubble"}, int'(idex_bubble), int'(exp_bub));
        chk({tag, ".busy"}, int'(busy), int'(exp_busy));
        chk({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
        chk({tag, ".flush_cnt"}, int'(flush_cnt), m_flush);
        chk({tag, ".stall_cnt_w2"}, int'(stall_cnt2), m_stall2);
        chk({tag, ".flush_cnt_w2"}, int'(flush_cnt2), m_flush2);
    endtask

    task automatic model_reset();
        pend = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    endtask

    // Inputs are set by the caller just after a rising edge; check mid-cycle.
    task automatic do_cycle(input string tag);
        #2;
        predict();
        check_all(tag);
        @(posedge clk);
        if (!hold) begin
            if (pend > 0) pend--;
            else if (exp_n > 0) pend = exp_n - 1;
        end
        if (exp_bub) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall2 < 3) m_stall2++;
        end
        if (exp_flush) begin
            if (m_flush < 65535) m_flush++;
            if (m_flush2 < 3) m_flush2++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        hold = 0; id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_taken = 0;
        id_jump = 0; ex_memread = 0; ex_regwrite = 0; ex_wn = 5'd0;
        mem_memread = 0; mem_wn = 5'd0;
    endtask

    task automatic check_reset_values(input string tag);
        exp_pc = 1'b1; exp_ifid = 1'b1; exp_flush = 1'b0; exp_bub = 1'b0;
        exp_busy = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [5:0] ops [5];
        ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd4; ops[3] = 6'd35; ops[4] = 6'd43;

        // Reset with a live load-use pattern on the inputs.
        ex_memread = 1; ex_wn = 5'd8; id_rs = 5'd8;
        #3;
        model_reset();
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();

        // Load-use: one bubble, then run.
        ex_memread = 1; ex_wn = 5'd8; id_op = 6'd0; id_rs = 5'd8;
        do_cycle("lu_detect");
        ex_memread = 0;
        do_cycle("lu_after");

        // Load feeding beq: two bubbles, taken ignored, then flush.
        clear_inputs();
        ex_memread = 1; ex_wn = 5'd9; id_op = 6'd4; id_rt = 5'd9; id_taken = 1;
        do_cycle("ldbr_detect");
        do_cycle("ldbr_stall");
        ex_memread = 0;
        do_cycle("ldbr_resolve");
        id_taken = 0;
        do_cycle("ldbr_idle");

        // ALU result feeding beq: one bubble, then taken branch flushes.
        clear_inputs();
        ex_regwrite = 1; ex_wn = 5'd5; id_op = 6'd4; id_rs = 5'd5;
        do_cycle("alubr_detect");
        ex_regwrite = 0; id_taken = 1;
        do_cycle("alubr_flush");
        id_taken = 0;
        do_cycle("alubr_idle");

        // Load in MEM feeding beq; jump flush.
        clear_inputs();
        mem_memread = 1; mem_wn = 5'd12; id_op = 6'd4; id_rt = 5'd12;
        do_cycle("membr_detect");
        mem_memread = 0; id_op = 6'd2; id_jump = 1;
        do_cycle("jump_flush");

        // Register zero and lw (rt not a source) never stall.
        clear_inputs();
        ex_memread = 1; ex_wn = 5'd0; id_rs = 5'd0;
        do_cycle("r0_nostall");
        id_op = 6'd35; id_rt = 5'd7; ex_wn = 5'd7; id_rs = 5'd3;
        do_cycle("lw_rt_nostall");

        // Hold for three cycles inside STALL.
        clear_inputs();
        ex_memread = 1; ex_wn = 5'd9; id_op = 6'd4; id_rs = 5'd9;
        do_cycle("hold_enter");
        hold = 1;
        for (int i = 0; i < 3; i++) do_cycle("hold_frozen");
        hold = 0;
        do_cycle("hold_last_bubble");
        ex_memread = 0;
        do_cycle("hold_run");

        // Asynchronous reset asserted mid-STALL.
        ex_memread = 1; ex_wn = 5'd9; id_op = 6'd4; id_rs = 5'd9;
        do_cycle("rst_enter");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_midstall");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        do_cycle("rst_after");

        // Five load-use bubbles saturate the 2-bit counter at 3.
        ex_memread = 1; ex_wn = 5'd4; id_op = 6'd0; id_rt = 5'd4;
        for (int i = 0; i < 5; i++) do_cycle("sat_bubble");
        ex_memread = 0;
        do_cycle("sat_check");

        // Random traffic over a small register set so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            hold        = ($urandom_range(0, 7) == 0);
            id_op       = ops[$urandom_range(0, 4)];
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_taken    = 1'($urandom_range(0, 1));
            id_jump     = ($urandom_range(0, 5) == 0);
            ex_memread  = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_wn       = 5'($urandom_range(0, 3));
            mem_memread = 1'($urandom_range(0, 1));
            mem_wn      = 5'($urandom_range(0, 3));
            do_cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
